seq_divider: RTL and testbench

//  Multicycle signed integer divider; the division counterpart to the

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_cla_sub_stage.sv | 52 +++++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and sizing constants.
// Used by the divider and by the mult/div top.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CLA_BLOCK     = 8;

endpackage

// File: rtl/seq_divider_cla_sub_stage.sv
// N-bit carry-lookahead adder made of 8-bit lookahead blocks joined by a group carry chain.
// The divider uses it for the trial subtract and for the two's-complement negations.
module cla_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  localparam int GROUPS = (N + CLA_BLOCK - 1) / CLA_BLOCK;

  // Each block forms its internal carries as G | P & group_cin.
  // The block's own G/P then drives the next group carry.
  always_comb begin : cla
    logic gcar, gacc, pacc, gk, pk;
    int   k;
    // NOTE: every variable gets a value before any branch reads it, so no latches are inferred.
    s     = '0;
    c_out = 1'b0;
    gcar  = c_in;
    gacc  = 1'b0;
    pacc  = 1'b1;
    gk    = 1'b0;
    pk    = 1'b0;
    k     = 0;
    for (int grp = 0; grp < GROUPS; grp++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int i = 0; i < CLA_BLOCK; i++) begin
        k = grp * CLA_BLOCK + i;
        if (k < N) begin
          s[k] = x[k] ^ y[k] ^ (gacc | (pacc & gcar));
          gk   = x[k] & y[k];
          pk   = x[k] | y[k];
        end else begin
          gk = 1'b0;
          pk = 1'b0;
        end
        gacc = gk | (pk & gacc);
        pacc = pacc & pk;
        if (k == N - 1) c_out = gacc | (pacc & gcar);
      end
      gcar = gacc | (pacc & gcar);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider that performs one radix-2 step per cycle.
// Latency is a fixed WIDTH+2 cycles from ctrl_DIV to the one-cycle data_resultRDY pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [N-1:0]     r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic             sign_q;
  logic             exc;
  logic [CW-1:0]    cnt;

  logic [N-1:0]     r_sh;
  logic [N-1:0]     add_x, add_y, add_s;
  logic             add_cin, add_cout;

  assign r_sh = (r << 1) | N'(q[WIDTH-1]);

  // The divisor is kept in signed form. A negative divisor is added rather than
  // subtracted, so the single adder still yields R - |B|. Carry-out = 1 means the result is non-negative.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (ctrl_DIV) begin
      add_y   = ~{data_operandA[WIDTH-1], data_operandA};
      add_cin = 1'b1;
    end else if (state == S_RUN) begin
      add_x   = r_sh;
      add_y   = b[WIDTH-1] ? {b[WIDTH-1], b} : ~{b[WIDTH-1], b};
      add_cin = ~b[WIDTH-1];
    end else if (state == S_FIX) begin
      add_y   = ~{1'b0, q};
      add_cin = 1'b1;
    end
  end

  cla_sub_stage #(.N(N)) u_cla (
    .x     (add_x),
    .y     (add_y),
    .c_in  (add_cin),
    .s     (add_s),
    .c_out (add_cout)
  );

  // NOTE: all state is updated with non-blocking assignments, so every branch sees the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      r              <= '0;
      q              <= '0;
      b              <= '0;
      sign_q         <= 1'b0;
      exc            <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        S_IDLE: ;
        S_RUN: begin
          if (add_cout) begin
            r <= add_s;
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= r_sh;
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (sign_q) q <= add_s[WIDTH-1:0];
          state <= S_DONE;
        end
        S_DONE: begin
          data_result    <= exc ? '0 : q;
          data_exception <= exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
      // A start in any state, including DONE, restarts from cycle 0. The assignments below take priority over the case above.
      if (ctrl_DIV) begin
        q      <= data_operandA[WIDTH-1] ? add_s[WIDTH-1:0] : data_operandA;
        b      <= data_operandB;
        sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        exc    <= (data_operandB == '0) ||
                  ((data_operandA == MIN_INT) && (data_operandB == '1));
        r      <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
        state  <= S_RUN;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider. Expected {quotient, exception, ready cycle} entries are queued at
// start, and the results observed at each data_resultRDY pulse are matched against them.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         exc;
    logic [31:0]  cyc;
  } res_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  logic [31:0]  cyc = '0;
  res_t         exp_q[$];
  res_t         obs_q[$];
  int           tests = 0;
  int           fails = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (data_resultRDY === 1'b1) obs_q.push_back({data_result, data_exception, cyc});

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, quo;
    sa = a;
    sb = b;
    if (b == '0 || (a == {1'b1, {(W-1){1'b0}}} && b == '1)) return {1'b1, {W{1'b0}}};
    quo = sa / sb;
    return {1'b0, quo};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ee);
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    exp_q.push_back({er, ee, 32'(cyc + W + 2)});
  endtask

  task automatic get_result(output res_t o, output res_t e, output bit got);
    int n = 0;
    o = '0;
    e = '0;
    while (obs_q.size() == 0 && n < W + 12) begin
      @(negedge clock);
      n++;
    end
    got = (obs_q.size() != 0) && (exp_q.size() != 0);
    if (obs_q.size() != 0) o = obs_q.pop_front();
    if (exp_q.size() != 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
      fails++;
      $display("FAIL reset_state got res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
  endtask

  task automatic test_signs();
    logic [W-1:0] a_t[4] = '{32'd100, -32'd100, 32'd100, -32'd100};
    logic [W-1:0] b_t[4] = '{32'd7, 32'd7, -32'd7, -32'd7};
    logic [W-1:0] r_t[4] = '{32'd14, 32'hFFFF_FFF2, -32'd14, 32'd14};
    res_t o, e;
    bit got;
    for (int i = 0; i < 4; i++) begin
      start_op(a_t[i], b_t[i], r_t[i], 1'b0);
      get_result(o, e, got);
      tests++;
      if (!got || o !== e) begin
        fails++;
        $display("FAIL signs[%0d] got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
                 i, o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
      end
    end
  endtask

  task automatic test_exceptions();
    logic [W-1:0] a_t[4] = '{32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] b_t[4] = '{32'd0, 32'd3, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] r_t[4] = '{32'd0, 32'd3, 32'd0, 32'h8000_0000};
    logic         x_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    res_t o, e;
    bit got;
    for (int i = 0; i < 4; i++) begin
      start_op(a_t[i], b_t[i], r_t[i], x_t[i]);
      get_result(o, e, got);
      tests++;
      if (!got || o !== e) begin
        fails++;
        $display("FAIL exceptions[%0d] got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
                 i, o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
      end
    end
  endtask

  task automatic test_abort();
    res_t o, e;
    bit got;
    start_op(32'd1000, 32'd10, 32'd100, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clock);
    start_op(32'd77, 32'd7, 32'd11, 1'b0);
    get_result(o, e, got);
    tests++;
    if (!got || o !== e) begin
      fails++;
      $display("FAIL abort got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
               o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
    end
    repeat (W + 4) @(negedge clock);
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL abort_extra_rdy got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    res_t o, e;
    bit got;
    start_op(32'd50, 32'd5, 32'd10, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    tests++;
    if ({busy, data_result, data_exception} !== '0) begin
      fails++;
      $display("FAIL reset_mid_state got busy=%b res=%h exc=%b want all 0",
               busy, data_result, data_exception);
    end
    repeat (W + 5) @(negedge clock);
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_rdy got %0d pulses want 0", obs_q.size());
      obs_q.delete();
    end
    start_op(32'd50, 32'd5, 32'd10, 1'b0);
    get_result(o, e, got);
    tests++;
    if (!got || o !== e) begin
      fails++;
      $display("FAIL reset_mid_after got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
               o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    bit got;
    start_op(-32'd81, 32'd9, -32'd9, 1'b0);
    repeat (W) @(negedge clock);
    start_op(32'd1234567, -32'd1000, -32'd1234, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy got %b want 1", busy);
    end
    for (int i = 0; i < 2; i++) begin
      get_result(o, e, got);
      tests++;
      if (!got || o !== e) begin
        fails++;
        $display("FAIL b2b[%0d] got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
                 i, o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [W:0]   m;
    res_t o, e;
    bit got;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
      m = model(a, b);
      start_op(a, b, m[W-1:0], m[W]);
      get_result(o, e, got);
      tests++;
      if (!got || o !== e) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h got res=%h exc=%b cyc=%0d want res=%h exc=%b cyc=%0d",
                 i, a, b, o.res, o.exc, o.cyc, e.res, e.exc, e.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_exceptions();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (4) @(negedge clock);
    tests++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover got obs=%0d exp=%0d want 0 and 0", obs_q.size(), exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
